// File: rtl/ef_wb_regs_pkg.sv
// Shared constants for the EF 0xFFxx interrupt / clock-control register page.
// Latency: n/a (constants, decode helper and byte-mask helper only).
// Backpressure: n/a.
package ef_wb_regs_pkg;

    localparam logic [7:0]  PAGE_TAG = 8'hFF;

    localparam logic [7:0]  OFF_IM   = 8'h00;
    localparam logic [7:0]  OFF_MIS  = 8'h04;
    localparam logic [7:0]  OFF_RIS  = 8'h08;
    localparam logic [7:0]  OFF_ICR  = 8'h0C;
    localparam logic [7:0]  OFF_GCLK = 8'h10;

    // Returned for any unmapped offset inside the page.
    localparam logic [31:0] FILLER   = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        REG_IM,
        REG_MIS,
        REG_RIS,
        REG_ICR,
        REG_GCLK,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_off(input logic [7:0] off);
        reg_sel_e r;
        case (off)
            OFF_IM:   r = REG_IM;
            OFF_MIS:  r = REG_MIS;
            OFF_RIS:  r = REG_RIS;
            OFF_ICR:  r = REG_ICR;
            OFF_GCLK: r = REG_GCLK;
            default:  r = REG_NONE;
        endcase
        return r;
    endfunction

    // Expand Wishbone byte selects into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/ef_irq_source.sv
// One interrupt source bit: level (RIS follows flag) or sticky rising-edge with W1C clear.
// Latency: RIS updates one clock after i_flag; a set beats a same-cycle clear.
// Backpressure: none, samples i_flag every cycle.
// Ports: clk_i/rst_n clock and async active-low reset; i_flag raw event; i_clr ICR clear
//        strobe (ignored in level mode); o_ris raw status bit.
module ef_irq_source #(
    parameter bit IS_EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic i_flag,
    input  logic i_clr,
    output logic o_ris
);

    logic r_flag_q;
    logic r_ris;
    logic w_set;
    logic w_hold;

    // Level mode: RIS is just the registered flag, nothing is held.
    // Edge mode: flags_q starts at 0, so a flag already high when reset is released
    // is seen as a rising edge.
    assign w_set  = IS_EDGE ? (i_flag & ~r_flag_q) : i_flag;
    assign w_hold = IS_EDGE ? (r_ris & ~i_clr)     : 1'b0;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_q <= 1'b0;
            r_ris    <= 1'b0;
        end else begin
            r_flag_q <= i_flag;
            r_ris    <= w_set | w_hold;
        end
    end

    assign o_ris = r_ris;

endmodule

// File: rtl/ef_wb_irq_regs.sv
// Wishbone register page 0xFFxx: IM/MIS/RIS/ICR/GCLK for NUM_FLAGS sources, irq_o and clock enable.
// Latency: ack_o and dat_o one cycle after request; irq_o two cycles after flags_i.
// Backpressure: ack deasserts for one cycle after each transfer, so transfers are 2 cycles each.
// Ports: clk_i/rst_n clock and async active-low reset; adr_i/dat_i/sel_i/cyc_i/stb_i/we_i
//        Wishbone slave inputs; dat_o/ack_o slave response; hit_o combinational page hit;
//        flags_i raw core events; clk_en_o GCLK[0]; irq_o registered interrupt request.
module ef_wb_irq_regs
    import ef_wb_regs_pkg::*;
#(
    parameter int          NUM_FLAGS  = 16,
    parameter logic [31:0] EDGE_MASK  = 32'h0,
    parameter logic        GCLK_RESET = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [15:0]          adr_i,
    input  logic [31:0]          dat_i,
    input  logic [3:0]           sel_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    output logic                 hit_o,
    input  logic [NUM_FLAGS-1:0] flags_i,
    output logic                 clk_en_o,
    output logic                 irq_o
);

    if (NUM_FLAGS < 1 || NUM_FLAGS > 32) begin : g_bad_num_flags
        $error("ef_wb_irq_regs: NUM_FLAGS must be within 1..32");
    end

    // Bits at or above NUM_FLAGS are tied to 0 in IM and RIS.
    localparam logic [31:0] FLAG_MASK = (NUM_FLAGS >= 32) ? 32'hFFFF_FFFF
                                                           : ((32'd1 << NUM_FLAGS) - 32'd1);

    logic                 r_ack;
    logic [31:0]          r_dat;
    logic [31:0]          r_im;
    logic                 r_gclk;
    logic                 r_irq;

    logic                 w_hit;
    logic                 w_req;
    logic                 w_wr;
    reg_sel_e             w_reg;
    logic [31:0]          w_be;
    logic [31:0]          w_ris;
    logic [31:0]          w_rdata;
    logic                 w_wr_icr;
    logic [NUM_FLAGS-1:0] w_clr;

    assign w_hit = (adr_i[15:8] == PAGE_TAG);
    assign hit_o = w_hit;

    // ~r_ack forces an idle cycle after each ack, so a held strobe is one transfer per 2 cycles.
    assign w_req = cyc_i & stb_i & w_hit & ~r_ack;
    assign w_wr  = w_req & we_i;
    assign w_reg = decode_off(adr_i[7:0]);
    assign w_be  = byte_mask(sel_i);

    assign w_wr_icr = w_wr & (w_reg == REG_ICR);
    assign w_clr    = dat_i[NUM_FLAGS-1:0] & w_be[NUM_FLAGS-1:0] & {NUM_FLAGS{w_wr_icr}};

    for (genvar i = 0; i < 32; i++) begin : g_src
        if (i < NUM_FLAGS) begin : g_on
            ef_irq_source #(
                .IS_EDGE (EDGE_MASK[i])
            ) u_src (
                .clk_i  (clk_i),
                .rst_n  (rst_n),
                .i_flag (flags_i[i]),
                .i_clr  (w_clr[i]),
                .o_ris  (w_ris[i])
            );
        end else begin : g_off
            assign w_ris[i] = 1'b0;
        end
    end

    // Read mux sees register values before this edge's writes/updates.
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_IM:   w_rdata = r_im;
            REG_MIS:  w_rdata = w_ris & r_im;
            REG_RIS:  w_rdata = w_ris;
            REG_ICR:  w_rdata = '0;
            REG_GCLK: w_rdata = {31'd0, r_gclk};
            default:  w_rdata = FILLER;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_im   <= '0;
            r_gclk <= GCLK_RESET;
            r_irq  <= 1'b0;
        end else begin
            r_ack <= w_req;
            // Cleared whenever no request is captured, so dat_o is 0 whenever ack_o is 0.
            r_dat <= w_req ? w_rdata : '0;
            if (w_wr && (w_reg == REG_IM)) begin
                r_im <= ((r_im & ~w_be) | (dat_i & w_be)) & FLAG_MASK;
            end
            if (w_wr && (w_reg == REG_GCLK) && sel_i[0]) begin
                r_gclk <= dat_i[0];
            end
            r_irq <= |(w_ris & r_im);
        end
    end

    assign ack_o    = r_ack;
    assign dat_o    = r_dat;
    assign clk_en_o = r_gclk;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_ef_wb_irq_regs.sv
// Directed bench for ef_wb_irq_regs: vector table of bus accesses plus hand-written
// sequences for interrupt timing, set/clear collision and reset during a transfer.
// DUT built with NUM_FLAGS=16, source 0 edge, others level, GCLK reset value 1.
module tb_ef_wb_irq_regs;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;
    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        hit_o;
    logic [15:0] flags;
    logic        clk_en_o;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    ef_wb_irq_regs #(
        .NUM_FLAGS  (16),
        .EDGE_MASK  (32'h0000_0001),
        .GCLK_RESET (1'b1)
    ) dut (
        .clk_i    (clk),
        .rst_n    (rst_n),
        .adr_i    (s_adr),
        .dat_i    (s_dat),
        .sel_i    (s_sel),
        .cyc_i    (s_cyc),
        .stb_i    (s_stb),
        .we_i     (s_we),
        .dat_o    (dat_o),
        .ack_o    (ack_o),
        .hit_o    (hit_o),
        .flags_i  (flags),
        .clk_en_o (clk_en_o),
        .irq_o    (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One Wishbone transfer; gives up after 4 cycles without ack (got=0, rdat=0).
    task automatic bus(input logic [15:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat, output logic got);
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_adr = adr; s_we = we; s_dat = dat; s_sel = sel;
        got  = 1'b0;
        rdat = '0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk); #1;
            if (ack_o) begin
                got  = 1'b1;
                rdat = dat_o;
            end
        end
        @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        logic        g;
        bus(adr, 1'b0, 32'h0, 4'hF, d, g);
        check({name, "_ack"}, {31'd0, g}, 32'd1);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        logic        g;
        bus(adr, 1'b1, dat, sel, d, g);
        check("wr_ack", {31'd0, g}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[24];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        g;
        logic [3:0]  pat;

        vecs[0]  = '{16'hFF00, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vecs[1]  = '{16'hFF04, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vecs[2]  = '{16'hFF08, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vecs[3]  = '{16'hFF10, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0001};
        vecs[4]  = '{16'hFF0C, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vecs[5]  = '{16'hFF00, 1'b1, 32'hFFFF_FFFF, 4'h1, 1'b1, 32'h0};
        vecs[6]  = '{16'hFF00, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_00FF};
        vecs[7]  = '{16'hFF00, 1'b1, 32'hFFFF_FFFF, 4'hC, 1'b1, 32'h0};
        vecs[8]  = '{16'hFF00, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_00FF};
        vecs[9]  = '{16'hFF00, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
        vecs[10] = '{16'hFF00, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_FFFF};
        vecs[11] = '{16'hFF20, 1'b0, 32'h0,         4'hF, 1'b1, 32'hDEAD_BEEF};
        vecs[12] = '{16'h0010, 1'b0, 32'h0,         4'hF, 1'b0, 32'h0000_0000};
        vecs[13] = '{16'h0010, 1'b1, 32'h0,         4'hF, 1'b0, 32'h0};
        vecs[14] = '{16'hFF10, 1'b1, 32'h0,         4'h1, 1'b1, 32'h0};
        vecs[15] = '{16'hFF10, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vecs[16] = '{16'hFF10, 1'b1, 32'h1,         4'hE, 1'b1, 32'h0};
        vecs[17] = '{16'hFF10, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vecs[18] = '{16'hFF10, 1'b1, 32'h1,         4'h1, 1'b1, 32'h0};
        vecs[19] = '{16'hFF10, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0001};
        vecs[20] = '{16'hFF20, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 32'h0};
        vecs[21] = '{16'hFF00, 1'b1, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[22] = '{16'hFF00, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vecs[23] = '{16'hFF04, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000};

        rst_n = 1'b0;
        s_adr = '0; s_dat = '0; s_sel = '0; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        flags = '0;
        #23;
        check("rst_ack",    {31'd0, ack_o},    32'd0);
        check("rst_dat",    dat_o,             32'd0);
        check("rst_irq",    {31'd0, irq_o},    32'd0);
        check("rst_clk_en", {31'd0, clk_en_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Held strobe: ack pattern 1,0,1,0 shows one-cycle ack and 2-cycle spacing.
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_adr = 16'hFF00; s_we = 1'b0; s_sel = 4'hF;
        pat = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            pat = {pat[2:0], ack_o};
        end
        @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0;
        check("ack_spacing", {28'd0, pat}, 32'h0000_000A);

        for (int i = 0; i < 24; i++) begin
            bus(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, d, g);
            check($sformatf("vec%0d_ack", i), {31'd0, g}, {31'd0, vecs[i].exp_ack});
            if (!vecs[i].we) check($sformatf("vec%0d_dat", i), d, vecs[i].exp_dat);
        end
        check("clk_en_after_vecs", {31'd0, clk_en_o}, 32'd1);

        // hit_o is purely combinational on the address.
        @(negedge clk);
        s_adr = 16'h0010; #1;
        check("hit_0010", {31'd0, hit_o}, 32'd0);
        s_adr = 16'hFF20; #1;
        check("hit_ff20", {31'd0, hit_o}, 32'd1);

        // Edge source 0: one-cycle pulse, sticky RIS, irq two cycles later, W1C clear.
        wr(16'hFF00, 32'h1, 4'hF);
        @(negedge clk); flags[0] = 1'b1;
        check("e_irq_pre", {31'd0, irq_o}, 32'd0);
        @(negedge clk); flags[0] = 1'b0;
        check("e_irq_1cyc", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        check("e_irq_2cyc", {31'd0, irq_o}, 32'd1);
        rd_check("e_ris_sticky", 16'hFF08, 32'h1);
        rd_check("e_mis", 16'hFF04, 32'h1);
        wr(16'hFF0C, 32'h1, 4'hF);
        check("e_irq_clr_edge", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        check("e_irq_cleared", {31'd0, irq_o}, 32'd0);
        rd_check("e_ris_cleared", 16'hFF08, 32'h0);

        // Level source 3: ICR has no effect, irq follows the flag.
        wr(16'hFF00, 32'h8, 4'hF);
        @(negedge clk); flags[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("l_irq_on", {31'd0, irq_o}, 32'd1);
        wr(16'hFF0C, 32'h8, 4'hF);
        rd_check("l_ris_icr", 16'hFF08, 32'h8);
        check("l_irq_still", {31'd0, irq_o}, 32'd1);
        @(negedge clk); flags[3] = 1'b0;
        @(negedge clk);
        check("l_irq_lag", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        check("l_irq_off", {31'd0, irq_o}, 32'd0);
        rd_check("l_ris_off", 16'hFF08, 32'h0);

        // Rising edge on source 0 in the same cycle as an ICR clear: set wins.
        wr(16'hFF00, 32'h1, 4'hF);
        @(negedge clk);
        flags[0] = 1'b1;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 16'hFF0C; s_dat = 32'h1; s_sel = 4'hF;
        @(posedge clk); #1;
        check("c_ack", {31'd0, ack_o}, 32'd1);
        @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        rd_check("c_ris_set_wins", 16'hFF08, 32'h1);
        wr(16'hFF0C, 32'h1, 4'hF);
        rd_check("c_ris_clr", 16'hFF08, 32'h0);
        flags[0] = 1'b0;

        // Reset asserted while a GCLK write is being acked.
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 16'hFF10; s_dat = 32'h0; s_sel = 4'h1;
        @(posedge clk); #1;
        check("r_ack_before", {31'd0, ack_o}, 32'd1);
        check("r_gclk_written", {31'd0, clk_en_o}, 32'd0);
        #1 rst_n = 1'b0;
        flags[0] = 1'b1;
        #1;
        check("r_ack_drop", {31'd0, ack_o}, 32'd0);
        check("r_gclk_reset", {31'd0, clk_en_o}, 32'd1);
        check("r_dat_zero", dat_o, 32'd0);
        @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("r_gclk_read", 16'hFF10, 32'h1);
        rd_check("r_im_read", 16'hFF00, 32'h0);
        rd_check("r_flag_high_edge", 16'hFF08, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
